uart_wb_feeder: RTL and testbench

Wishbone bus master that sits directly upstream of the UART top level and drives its 8-bit slave port. It accepts bytes from a valid/ready stream and buffers them in a local FIFO. It polls the UART line status register and writes bytes into the transmit holding register in bursts sized to the UART transmit FIFO. An optional power-up sequence programs the divisor latch, line control and FIFO control registers before any data is sent.

---
 rtl/uart_wb_feeder.sv | 241 ++++++++++++++++++++++++
 tb/tb_uart_wb_feeder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_wb_feeder.sv
// Wishbone master that drains a 16-entry byte FIFO into the UART THR in LSR-gated bursts.
// Define UART_FEEDER_INIT_EN to program LCR/DLL/DLM/FCR after reset.
module uart_wb_feeder #(
  parameter int          ADDR_W   = 5,
  parameter int          FIFO_AW  = 4,
  parameter int          TX_BURST = 16,
  parameter logic [15:0] DIVISOR  = 16'd27,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [7:0]        s_data_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [7:0]        wbm_dat_o,
  input  logic [7:0]        wbm_dat_i,
  output logic              wbm_we_o,
  output logic              wbm_stb_o,
  output logic              wbm_cyc_o,
  input  logic              wbm_ack_i,
  output logic [FIFO_AW:0]  level_o,
  output logic              busy_o,
  output logic              err_o
);
  localparam int                BW      = $clog2(TX_BURST + 1);
  localparam logic [FIFO_AW:0]  DEPTH   = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [ADDR_W-1:0] ADR_THR = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADR_LSR = ADDR_W'(5);

  typedef enum logic [2:0] {
`ifdef UART_FEEDER_INIT_EN
    INIT,
`endif
    IDLE,
    POLL,
    WRITE,
    TOUT
  } state_t;

`ifdef UART_FEEDER_INIT_EN
  localparam state_t RESET_STATE = INIT;
`else
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t              state_q, state_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [7:0]          dat_q, dat_d;
  logic                err_q, err_d;
  logic                busy_q, busy_d;
  logic [7:0]          tout_q, tout_d;
  logic [BW-1:0]       burst_q, burst_d;

  logic [7:0]          mem_q [2**FIFO_AW];
  logic [FIFO_AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]    level_q, level_d;
  logic                push, pop, ack, timeout;
  logic                unused_in;

  assign s_ready_o = (level_q != DEPTH);
  assign push      = s_valid_i && s_ready_o;
  // Acks outside an active strobe belong to nobody and are discarded.
  assign ack       = wbm_ack_i && stb_q;
  assign pop       = ack && (state_q == WRITE);
  assign timeout   = stb_q && !wbm_ack_i && (tout_q == TIMEOUT - 8'd1);

  always_comb begin
    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + (FIFO_AW + 1)'(1);
    end else if (pop && !push) begin
      level_d = level_q - (FIFO_AW + 1)'(1);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= s_data_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
      level_q <= level_d;
    end
  end

`ifdef UART_FEEDER_INIT_EN
  logic [2:0]        step_q, step_d;
  logic [ADDR_W-1:0] init_adr;
  logic [7:0]        init_dat;

  always_comb begin
    init_adr = ADDR_W'(3);
    init_dat = 8'h83;
    case (step_q)
      3'd1:    begin init_adr = ADDR_W'(0); init_dat = DIVISOR[7:0];  end
      3'd2:    begin init_adr = ADDR_W'(1); init_dat = DIVISOR[15:8]; end
      3'd3:    begin init_adr = ADDR_W'(3); init_dat = 8'h03;         end
      3'd4:    begin init_adr = ADDR_W'(2); init_dat = 8'hC7;         end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      step_q <= 3'd0;
    end else begin
      step_q <= step_d;
    end
  end

  assign unused_in = ^{wbm_dat_i[7:6], wbm_dat_i[4:0]};
`else
  assign unused_in = ^{wbm_dat_i[7:6], wbm_dat_i[4:0], DIVISOR};
`endif

  // A new access is launched by raising stb together with its address/data;
  // dropping stb on ack or timeout guarantees one idle bus cycle in between.
  always_comb begin
    state_d = state_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    err_d   = err_q;
    burst_d = burst_q;
    tout_d  = stb_q ? tout_q + 8'd1 : 8'd0;
`ifdef UART_FEEDER_INIT_EN
    step_d  = step_q;
`endif
    case (state_q)
`ifdef UART_FEEDER_INIT_EN
      INIT: begin
        if (!stb_q) begin
          stb_d = 1'b1;
          we_d  = 1'b1;
          adr_d = init_adr;
          dat_d = init_dat;
        end else if (ack || timeout) begin
          stb_d = 1'b0;
          if (timeout) err_d = 1'b1;
          if (step_q == 3'd4) begin
            state_d = IDLE;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
`endif
      IDLE: begin
        if (level_q != '0) begin
          state_d = POLL;
          stb_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = ADR_LSR;
          dat_d   = 8'h00;
        end
      end
      POLL: begin
        if (ack) begin
          stb_d = 1'b0;
          if (wbm_dat_i[5]) begin
            burst_d = BW'(TX_BURST);
            state_d = WRITE;
          end else begin
            state_d = IDLE;
          end
        end else if (timeout) begin
          stb_d   = 1'b0;
          err_d   = 1'b1;
          state_d = TOUT;
        end
      end
      WRITE: begin
        if (!stb_q) begin
          stb_d = 1'b1;
          we_d  = 1'b1;
          adr_d = ADR_THR;
          dat_d = mem_q[rd_ptr_q];
        end else if (ack) begin
          stb_d   = 1'b0;
          burst_d = burst_q - BW'(1);
          if ((burst_q == BW'(1)) || (level_d == '0)) begin
            state_d = IDLE;
          end
        end else if (timeout) begin
          stb_d   = 1'b0;
          err_d   = 1'b1;
          state_d = TOUT;
        end
      end
      TOUT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || (level_d != '0);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q <= RESET_STATE;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= 8'h00;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      tout_q  <= 8'd0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      tout_q  <= tout_d;
      burst_q <= burst_d;
    end
  end

  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_we_o  = we_q;
  assign wbm_stb_o = stb_q;
  assign wbm_cyc_o = stb_q;
  assign level_o   = level_q;
  assign busy_o    = busy_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_uart_wb_feeder.sv
// Self-checking bench for uart_wb_feeder: a Wishbone slave model logs every acked
// access, and a byte-order/burst-allowance model checks the log.
module tb_uart_wb_feeder;
  localparam int TX_BURST = 16;
  localparam int TIMEOUT  = 255;

  typedef struct {
    logic [4:0] adr;
    logic       we;
    logic [7:0] dato;
    logic [7:0] lsr;
    int         start;
  } txn_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] s_data_i = 8'h00;
  logic       s_valid_i = 1'b0;
  logic       s_ready_o;
  logic [4:0] wbm_adr_o;
  logic [7:0] wbm_dat_o;
  logic [7:0] wbm_dat_i = 8'h00;
  logic       wbm_we_o, wbm_stb_o, wbm_cyc_o;
  logic       wbm_ack_i = 1'b0;
  logic [4:0] level_o;
  logic       busy_o, err_o;

  int         checks = 0;
  int         failures = 0;
  int         cycCnt = 0;
  int         ackLat = 1;
  bit         noAckWrite = 1'b0;
  logic [7:0] lsrDefault = 8'h60;
  logic [7:0] lsrQ[$];
  logic [7:0] expQ[$];
  txn_t       txnQ[$];
  int         runs[$];
  int         nReads;

`ifdef UART_FEEDER_INIT_EN
  logic [4:0] initAdr [5] = '{5'd3, 5'd0, 5'd1, 5'd3, 5'd2};
  logic [7:0] initDat [5] = '{8'h83, 8'h1B, 8'h00, 8'h03, 8'hC7};
`endif

  uart_wb_feeder #(
    .ADDR_W(5), .FIFO_AW(4), .TX_BURST(TX_BURST), .DIVISOR(16'h001B), .TIMEOUT(8'd255)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst_n),
    .s_data_i (s_data_i),
    .s_valid_i(s_valid_i),
    .s_ready_o(s_ready_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_we_o (wbm_we_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_ack_i(wbm_ack_i),
    .level_o  (level_o),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycCnt <= cycCnt + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave model: acks after ackLat cycles, serves LSR reads, checks hold stability.
  txn_t cur;
  bit   inCyc = 1'b0;
  int   waitCnt = 0;
  always @(negedge clk) begin
    wbm_ack_i = 1'b0;
    checkOutput("cyc_eq_stb", 32'(wbm_cyc_o), 32'(wbm_stb_o));
    if (wbm_stb_o) begin
      if (!inCyc) begin
        inCyc     = 1'b1;
        waitCnt   = 0;
        cur.adr   = wbm_adr_o;
        cur.we    = wbm_we_o;
        cur.dato  = wbm_dat_o;
        cur.lsr   = 8'h00;
        cur.start = cycCnt;
      end else begin
        checkOutput("adr_stable", 32'(wbm_adr_o), 32'(cur.adr));
        checkOutput("we_stable", 32'(wbm_we_o), 32'(cur.we));
        checkOutput("dat_stable", 32'(wbm_dat_o), 32'(cur.dato));
      end
      if (!(noAckWrite && cur.we)) begin
        waitCnt++;
        if (waitCnt >= ackLat) begin
          if (!cur.we) begin
            cur.lsr   = (lsrQ.size() > 0) ? lsrQ.pop_front() : lsrDefault;
            wbm_dat_i = cur.lsr;
          end
          wbm_ack_i = 1'b1;
          txnQ.push_back(cur);
        end
      end
    end else begin
      inCyc = 1'b0;
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    s_data_i  = b;
    s_valid_i = 1'b1;
    while (!s_ready_o && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready_o) begin
      checkOutput("push_ready", 32'(s_ready_o), 1);
    end else begin
      expQ.push_back(b);
    end
    @(negedge clk);
    s_valid_i = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    repeat (2) @(negedge clk);
    while ((busy_o || wbm_stb_o) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("idle_reached", 32'({busy_o, wbm_stb_o}), 0);
  endtask

  // Walks the acked-access log: LSR reads grant TX_BURST writes when THRE is set,
  // and every THR write must carry the oldest byte not yet sent.
  task automatic checkLog();
    int allow = 0;
    nReads = 0;
    runs.delete();
    while (txnQ.size() > 0) begin
      txn_t t;
      logic [7:0] want;
      t = txnQ.pop_front();
      if (!t.we) begin
        nReads++;
        checkOutput("lsr_adr", 32'(t.adr), 5);
        checkOutput("read_dat_o", 32'(t.dato), 0);
        if (t.lsr[5]) begin
          allow = TX_BURST;
          runs.push_back(0);
        end else begin
          allow = 0;
        end
      end else begin
        want = (expQ.size() > 0) ? expQ.pop_front() : ~t.dato;
        checkOutput("thr_adr", 32'(t.adr), 0);
        checkOutput("thr_allowed", 32'(allow > 0), 1);
        checkOutput("thr_byte", 32'(t.dato), 32'(want));
        if (allow > 0) allow--;
        if (runs.size() > 0) runs[runs.size() - 1]++;
      end
    end
  endtask

  initial begin
    int pushCyc, n, pollStart, wrStart, i0;

    repeat (3) @(negedge clk);
    checkOutput("rst_stb", 32'(wbm_stb_o), 0);
    checkOutput("rst_cyc", 32'(wbm_cyc_o), 0);
    checkOutput("rst_we", 32'(wbm_we_o), 0);
    checkOutput("rst_err", 32'(err_o), 0);
    checkOutput("rst_busy", 32'(busy_o), 0);
    checkOutput("rst_adr", 32'(wbm_adr_o), 0);
    checkOutput("rst_dat", 32'(wbm_dat_o), 0);
    checkOutput("rst_level", 32'(level_o), 0);
    checkOutput("rst_ready", 32'(s_ready_o), 1);
    rst_n = 1'b1;
    waitIdle(500);
`ifdef UART_FEEDER_INIT_EN
    checkOutput("init_count", 32'(txnQ.size()), 5);
    for (int i = 0; i < 5 && i < txnQ.size(); i++) begin
      checkOutput("init_we", 32'(txnQ[i].we), 1);
      checkOutput("init_adr", 32'(txnQ[i].adr), 32'(initAdr[i]));
      checkOutput("init_dat", 32'(txnQ[i].dato), 32'(initDat[i]));
    end
    checkOutput("init_stb_low", 32'(wbm_stb_o), 0);
`endif
    txnQ.delete();

    $display("[TB] three-byte burst");
    ackLat = 1;
    lsrDefault = 8'h60;
    pushCyc = cycCnt;
    applyStimulus(8'h41);
    applyStimulus(8'h42);
    applyStimulus(8'h43);
    checkOutput("level_three", 32'(level_o), 3);
    waitIdle(200);
    pollStart = (txnQ.size() > 0) ? txnQ[0].start : -1;
    wrStart   = (txnQ.size() > 1) ? txnQ[1].start : -1;
    checkOutput("poll_latency", 32'(pollStart - pushCyc), 2);
    checkOutput("write_latency", 32'(wrStart - pushCyc), 4);
    checkLog();
    checkOutput("basic_reads", 32'(nReads), 1);
    checkOutput("basic_runs", 32'(runs.size()), 1);
    checkOutput("basic_run0", 32'((runs.size() > 0) ? runs[0] : -1), 3);
    checkOutput("basic_level_end", 32'(level_o), 0);

    $display("[TB] twenty bytes through a full FIFO");
    lsrDefault = 8'h00;
    for (int i = 0; i < 16; i++) applyStimulus(8'($urandom));
    checkOutput("full_level", 32'(level_o), 16);
    checkOutput("full_ready", 32'(s_ready_o), 0);
    lsrDefault = 8'h60;
    for (int i = 0; i < 4; i++) applyStimulus(8'($urandom));
    waitIdle(500);
    checkLog();
    checkOutput("big_runs", 32'(runs.size()), 2);
    checkOutput("big_run0", 32'((runs.size() > 0) ? runs[0] : -1), 16);
    checkOutput("big_run1", 32'((runs.size() > 1) ? runs[1] : -1), 4);
    checkOutput("big_drained", 32'(expQ.size()), 0);

    $display("[TB] THRE held low for two polls");
    lsrQ.push_back(8'h00);
    lsrQ.push_back(8'h00);
    lsrQ.push_back(8'h20);
    applyStimulus(8'h99);
    waitIdle(200);
    checkLog();
    checkOutput("thre_reads", 32'(nReads), 3);
    checkOutput("thre_runs", 32'(runs.size()), 1);
    checkOutput("thre_run0", 32'((runs.size() > 0) ? runs[0] : -1), 1);

    $display("[TB] THR write never acked");
    noAckWrite = 1'b1;
    applyStimulus(8'h5A);
    n = 0;
    while (!(wbm_stb_o && wbm_we_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (wbm_stb_o && n < 400) begin
      @(negedge clk);
      n++;
    end
    noAckWrite = 1'b0;
    checkOutput("tout_len", 32'(n), TIMEOUT);
    checkOutput("tout_err", 32'(err_o), 1);
    checkOutput("tout_level", 32'(level_o), 1);
    waitIdle(200);
    checkLog();
    checkOutput("tout_retried", 32'(expQ.size()), 0);
    checkOutput("err_sticky", 32'(err_o), 1);

    $display("[TB] reset during a write strobe");
    noAckWrite = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(8'($urandom));
    n = 0;
    while (!(wbm_stb_o && wbm_we_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mrst_stb", 32'(wbm_stb_o), 0);
    checkOutput("mrst_cyc", 32'(wbm_cyc_o), 0);
    checkOutput("mrst_level", 32'(level_o), 0);
    checkOutput("mrst_ready", 32'(s_ready_o), 1);
    checkOutput("mrst_err", 32'(err_o), 0);
    @(negedge clk);
    noAckWrite = 1'b0;
    rst_n = 1'b1;
    expQ.delete();
    waitIdle(500);
    txnQ.delete();

    $display("[TB] randomized traffic");
    ackLat = $urandom_range(1, 3);
    for (int i = 0; i < 6; i++) lsrQ.push_back(8'($urandom_range(0, 255)));
    i0 = $urandom_range(10, 30);
    for (int i = 0; i < i0; i++) begin
      applyStimulus(8'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    waitIdle(3000);
    checkLog();
    checkOutput("rand_drained", 32'(expQ.size()), 0);
    checkOutput("rand_level", 32'(level_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
